pipelined_control_unit: RTL and testbench

- Next-generation control unit for the 5-stage pipelined RV32I core; replaces the single-cycle decoder pairing.
- Decodes the ID-stage instruction and carries its control bundle through internal ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six branch conditions plus JAL/JALR in EX, and handles stall, flush and illegal-instruction bubbles.
- Sits beside the datapath pipeline registers, which it does not own.

---
 rtl/pipelined_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: combinational ID decode, control bundle carried through ID/EX, EX/MEM and MEM/WB registers.
// EX controls one cycle after ID, MemWriteM two, WB controls three; stall, flush or a taken EX branch/jump load a bubble into EX.
module pipelined_control_unit #(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instr_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      zero_i,
    input  logic                      lt_i,
    input  logic                      ltu_i,
    output logic [2:0]                ImmSrcD_o,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE_o,
    output logic                      ALUSrcAE_o,
    output logic                      ALUSrcBE_o,
    output logic [1:0]                PCSrcE_o,
    output logic [1:0]                ResultSrcE_o,
    output logic                      RegWriteM_o,
    output logic                      MemWriteM_o,
    output logic                      RegWriteW_o,
    output logic [1:0]                ResultSrcW_o,
    output logic                      IllegalE_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASB = 4'd10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [3:0] alu;
        logic       src_a;
        logic       src_b;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_zero, f7_alt, alt_ok;
    logic [3:0] base_alu;
    logic       unused_instr;
    ctrl_t      dec;
    logic [2:0] imm_src;
    ctrl_t      ex_d, ex_q;
    logic       mem_reg_write_q, mem_mem_write_q, wb_reg_write_q;
    logic [1:0] mem_result_src_q, wb_result_src_q;
    logic       taken;
    logic [1:0] pc_src;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign f7_zero      = (instr_i[31:25] == 7'b0000000);
    assign f7_alt       = (instr_i[31:25] == 7'b0100000);
    assign alt_ok       = (funct3 == 3'b000) || (funct3 == 3'b101);
    assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        base_alu = ALU_ADD;
        case (funct3)
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            3'b111:  base_alu = ALU_AND;
            default: base_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.funct3 = funct3;
        imm_src    = 3'b000;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu       = f7_alt ? ((funct3 == 3'b000) ? ALU_SUB : ALU_SRA) : base_alu;
                dec.illegal   = !(f7_zero || (f7_alt && alt_ok));
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                dec.alu       = base_alu;
                // Only the shift-immediates carry a func7 field.
                if (funct3 == 3'b001) begin
                    dec.illegal = !f7_zero;
                end else if (funct3 == 3'b101) begin
                    dec.alu     = f7_alt ? ALU_SRA : ALU_SRL;
                    dec.illegal = !(f7_zero || f7_alt);
                end
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.src_b      = 1'b1;
                dec.illegal    = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.src_b     = 1'b1;
                dec.illegal   = (funct3 != 3'b010);
                imm_src       = 3'b001;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.alu     = ALU_SUB;
                dec.illegal = (funct3[2:1] == 2'b01);
                imm_src     = 3'b010;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                imm_src        = 3'b100;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.src_b      = 1'b1;
                dec.jalr       = 1'b1;
                dec.illegal    = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                dec.alu       = ALU_PASB;
                imm_src       = 3'b011;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.src_a     = 1'b1;
                dec.src_b     = 1'b1;
                imm_src       = 3'b011;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ex_q.funct3)
            3'b000:  taken = zero_i;
            3'b001:  taken = !zero_i;
            3'b100:  taken = lt_i;
            3'b101:  taken = !lt_i;
            3'b110:  taken = ltu_i;
            3'b111:  taken = !ltu_i;
            default: taken = 1'b0;
        endcase
        pc_src = 2'b00;
        if (ex_q.jump) begin
            pc_src = 2'b01;
        end else if (ex_q.jalr) begin
            pc_src = 2'b10;
        end else if (ex_q.branch && taken) begin
            pc_src = 2'b01;
        end
    end

    // An illegal instruction enters EX as a bubble that only flags itself.
    always_comb begin
        ex_d = dec;
        if (stall_i || flush_i || (pc_src != 2'b00)) begin
            ex_d = '0;
        end else if (dec.illegal) begin
            ex_d         = '0;
            ex_d.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q             <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_result_src_q <= 2'b00;
            wb_reg_write_q   <= 1'b0;
            wb_result_src_q  <= 2'b00;
        end else begin
            ex_q             <= ex_d;
            mem_reg_write_q  <= ex_q.reg_write;
            mem_mem_write_q  <= ex_q.mem_write;
            mem_result_src_q <= ex_q.result_src;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_result_src_q  <= mem_result_src_q;
        end
    end

    assign ImmSrcD_o     = imm_src;
    assign ALUControlE_o = ALU_CTRL_WIDTH'(ex_q.alu);
    assign ALUSrcAE_o    = ex_q.src_a;
    assign ALUSrcBE_o    = ex_q.src_b;
    assign PCSrcE_o      = pc_src;
    assign ResultSrcE_o  = ex_q.result_src;
    assign RegWriteM_o   = mem_reg_write_q;
    assign MemWriteM_o   = mem_mem_write_q;
    assign RegWriteW_o   = wb_reg_write_q;
    assign ResultSrcW_o  = wb_result_src_q;
    assign IllegalE_o    = ex_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: stimulus queues expected values tagged with a cycle,
// a negedge monitor compares every entry that falls due.
module tb_pipelined_control_unit;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_LW    = 32'h0080A283;
    localparam logic [31:0] I_LH    = 32'h00809283;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BF2   = 32'h0020A463;
    localparam logic [31:0] I_BLT   = 32'h0020C463;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_BGEU  = 32'h0020F463;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_SUB   = 32'h40310133;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h12345097;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_ADDI  = 32'hFFF10093;

    localparam int S_IMM = 0, S_ALU = 1, S_SRCA = 2, S_SRCB = 3, S_PCS = 4, S_RSE = 5;
    localparam int S_RWM = 6, S_MWM = 7, S_RWW = 8, S_RSW = 9, S_ILL = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        stall, flush, zero, lt, ltu;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic        src_a, src_b, reg_write_m, mem_write_m, reg_write_w, illegal_e;
    logic [1:0]  pc_src, result_src_e, result_src_w;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    pipelined_control_unit #(.INSTR_WIDTH(32), .ALU_CTRL_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .instr_i(instr), .stall_i(stall), .flush_i(flush),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
        .ImmSrcD_o(imm_src), .ALUControlE_o(alu_ctrl), .ALUSrcAE_o(src_a), .ALUSrcBE_o(src_b),
        .PCSrcE_o(pc_src), .ResultSrcE_o(result_src_e), .RegWriteM_o(reg_write_m),
        .MemWriteM_o(mem_write_m), .RegWriteW_o(reg_write_w), .ResultSrcW_o(result_src_w),
        .IllegalE_o(illegal_e)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_sig(int s);
        case (s)
            S_IMM:   return int'(imm_src);
            S_ALU:   return int'(alu_ctrl);
            S_SRCA:  return int'(src_a);
            S_SRCB:  return int'(src_b);
            S_PCS:   return int'(pc_src);
            S_RSE:   return int'(result_src_e);
            S_RWM:   return int'(reg_write_m);
            S_MWM:   return int'(mem_write_m);
            S_RWW:   return int'(reg_write_w);
            S_RSW:   return int'(result_src_w);
            default: return int'(illegal_e);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                checks++;
                if (q[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", q[i].name, q[i].cyc);
                end else if (get_sig(q[i].sig) != q[i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d expected %0d",
                             q[i].name, cyc, get_sig(q[i].sig), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int off, input int sig, input int val, input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic stl, input logic fls);
        instr = ins;
        stall = stl;
        flush = fls;
        tick();
    endtask

    // Branch in ID, then resolve it in EX with the given flags while a nop sits in ID.
    task automatic branch_case(input logic [31:0] ins, input logic z, input logic l, input logic lu,
                               input int pcs, input string name);
        issue(ins, 1'b0, 1'b0);
        zero = z;
        lt   = l;
        ltu  = lu;
        expect_at(0, S_PCS, pcs, name);
        issue(I_NOP, 1'b0, 1'b0);
        zero = 1'b0;
        lt   = 1'b0;
        ltu  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = I_ADD; stall = 1'b0; flush = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        tick();
        for (int s = S_ALU; s <= S_ILL; s++) expect_at(0, s, 0, "reset_state");
        tick();
        rst = 1'b0;
        expect_at(0, S_RWW, 0, "reset_hold_rww");
        expect_at(1, S_ALU, 0, "add_alu");
        expect_at(1, S_SRCB, 0, "add_srcb");
        expect_at(2, S_RWM, 1, "add_rwm");
        expect_at(3, S_RWW, 1, "add_rww");
        expect_at(3, S_RSW, 0, "add_rsw");
        issue(I_ADD, 1'b0, 1'b0);

        expect_at(0, S_IMM, 0, "lw_imm");
        expect_at(1, S_SRCB, 1, "lw_srcb");
        expect_at(1, S_RSE, 1, "lw_rse");
        expect_at(2, S_MWM, 0, "lw_mwm");
        expect_at(3, S_RWW, 1, "lw_rww");
        expect_at(3, S_RSW, 1, "lw_rsw");
        issue(I_LW, 1'b0, 1'b0);
        expect_at(0, S_IMM, 1, "sw_imm");
        expect_at(1, S_SRCB, 1, "sw_srcb");
        expect_at(2, S_MWM, 1, "sw_mwm");
        expect_at(2, S_RWM, 0, "sw_rwm");
        expect_at(3, S_RWW, 0, "sw_rww");
        issue(I_SW, 1'b0, 1'b0);

        expect_at(0, S_IMM, 2, "bne_imm");
        issue(I_BNE, 1'b0, 1'b0);
        expect_at(0, S_PCS, 1, "bne_taken");
        expect_at(1, S_PCS, 0, "squash_pcs");
        expect_at(2, S_RWM, 0, "squash_rwm");
        expect_at(3, S_RWW, 0, "squash_rww");
        issue(I_ADD, 1'b0, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);
        issue(I_BNE, 1'b0, 1'b0);
        zero = 1'b1;
        expect_at(0, S_PCS, 0, "bne_not_taken");
        expect_at(2, S_RWM, 1, "no_squash_rwm");
        issue(I_ADD, 1'b0, 1'b0);
        zero = 1'b0;
        issue(I_NOP, 1'b0, 1'b0);

        branch_case(I_BEQ,  1'b1, 1'b0, 1'b0, 1, "beq_z1");
        branch_case(I_BEQ,  1'b0, 1'b1, 1'b1, 0, "beq_z0");
        branch_case(I_BGE,  1'b0, 1'b0, 1'b1, 1, "bge_lt0");
        branch_case(I_BGE,  1'b0, 1'b1, 1'b0, 0, "bge_lt1");
        branch_case(I_BLTU, 1'b0, 1'b0, 1'b1, 1, "bltu_ltu1");
        branch_case(I_BLTU, 1'b0, 1'b1, 1'b0, 0, "bltu_ltu0");
        branch_case(I_BLT,  1'b0, 1'b1, 1'b0, 1, "blt_lt1");
        branch_case(I_BGEU, 1'b0, 1'b1, 1'b0, 1, "bgeu_ltu0");
        branch_case(I_BGEU, 1'b0, 1'b0, 1'b1, 0, "bgeu_ltu1");
        expect_at(1, S_ILL, 1, "branch_f3_010_illegal");
        branch_case(I_BF2,  1'b1, 1'b1, 1'b1, 0, "branch_f3_010_pcs");

        expect_at(0, S_IMM, 0, "jalr_imm");
        expect_at(1, S_PCS, 2, "jalr_pcs");
        expect_at(1, S_SRCB, 1, "jalr_srcb");
        expect_at(1, S_RSE, 2, "jalr_rse");
        expect_at(3, S_RWW, 1, "jalr_rww");
        expect_at(3, S_RSW, 2, "jalr_rsw");
        issue(I_JALR, 1'b0, 1'b0);
        expect_at(2, S_RWM, 0, "jalr_squash_rwm");
        issue(I_NOP, 1'b0, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);
        expect_at(0, S_IMM, 4, "jal_imm");
        expect_at(1, S_PCS, 1, "jal_pcs");
        expect_at(1, S_RSE, 2, "jal_rse");
        issue(I_JAL, 1'b0, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);

        expect_at(1, S_ALU, 0, "stall_bubble_alu");
        expect_at(2, S_RWM, 0, "stall_bubble_rwm");
        issue(I_SUB, 1'b1, 1'b0);
        expect_at(1, S_ALU, 1, "sub_alu");
        expect_at(2, S_RWM, 1, "sub_rwm");
        issue(I_SUB, 1'b0, 1'b0);
        expect_at(1, S_ALU, 0, "stall_flush_alu");
        expect_at(2, S_RWM, 0, "stall_flush_rwm");
        issue(I_SUB, 1'b1, 1'b1);
        expect_at(1, S_ALU, 0, "flush_alu");
        issue(I_SUB, 1'b0, 1'b1);
        issue(I_NOP, 1'b0, 1'b0);
        issue(I_BNE, 1'b0, 1'b0);
        expect_at(0, S_PCS, 1, "branch_stall_pcs");
        expect_at(1, S_ALU, 0, "branch_stall_alu");
        expect_at(1, S_PCS, 0, "branch_stall_pcs_next");
        issue(I_SUB, 1'b1, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);

        expect_at(1, S_ILL, 1, "illegal_e");
        expect_at(1, S_ALU, 0, "illegal_alu");
        expect_at(1, S_RSE, 0, "illegal_rse");
        expect_at(2, S_RWM, 0, "illegal_rwm");
        expect_at(2, S_MWM, 0, "illegal_mwm");
        expect_at(2, S_ILL, 0, "illegal_clears");
        expect_at(3, S_RWW, 0, "illegal_rww");
        issue(I_BAD, 1'b0, 1'b0);
        issue(I_NOP, 1'b0, 1'b0);
        expect_at(1, S_ILL, 0, "illegal_stalled");
        issue(I_BAD, 1'b1, 1'b0);
        expect_at(1, S_ILL, 1, "r_bad_func7");
        issue(I_MUL, 1'b0, 1'b0);
        expect_at(1, S_ILL, 1, "load_bad_func3");
        issue(I_LH, 1'b0, 1'b0);
        expect_at(0, S_IMM, 3, "lui_imm");
        expect_at(1, S_ALU, 10, "lui_alu");
        expect_at(1, S_SRCB, 1, "lui_srcb");
        expect_at(1, S_ILL, 0, "lui_legal");
        expect_at(3, S_RWW, 1, "lui_rww");
        issue(I_LUI, 1'b0, 1'b0);
        expect_at(0, S_IMM, 3, "auipc_imm");
        expect_at(1, S_SRCA, 1, "auipc_srca");
        expect_at(1, S_ALU, 0, "auipc_alu");
        issue(I_AUIPC, 1'b0, 1'b0);
        expect_at(1, S_ALU, 9, "srai_alu");
        expect_at(1, S_SRCB, 1, "srai_srcb");
        issue(I_SRAI, 1'b0, 1'b0);
        expect_at(1, S_ALU, 0, "addi_alu");
        expect_at(1, S_ILL, 0, "addi_func7_ignored");
        issue(I_ADDI, 1'b0, 1'b0);

        issue(I_LW, 1'b0, 1'b0);
        rst = 1'b1;
        issue(I_LW, 1'b0, 1'b0);
        rst = 1'b0;
        for (int s = S_ALU; s <= S_ILL; s++) expect_at(0, s, 0, "midstream_reset");
        issue(I_NOP, 1'b0, 1'b0);

        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_queue: got %0d entries left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
